// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, scan phase encoding and the phase-advance helper
// used by both the horizontal and vertical scan FSMs.
package vga_timing_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned DEF_CLK_DIV  = 2;
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } scan_phase_e;

   // Phase the scan enters when its counter moves to 'pos'; a phase is left
   // only when the counter lands exactly on the first position of the next one.
   function automatic scan_phase_e next_phase(input scan_phase_e cur,
                                              input int unsigned pos,
                                              input int unsigned active_len,
                                              input int unsigned fp_len,
                                              input int unsigned sync_len);
      next_phase = cur;
      case (cur)
         ACTIVE:  if (pos == active_len)                     next_phase = FRONT;
         FRONT:   if (pos == active_len + fp_len)            next_phase = SYNC;
         SYNC:    if (pos == active_len + fp_len + sync_len) next_phase = BACK;
         BACK:    if (pos == 0)                              next_phase = ACTIVE;
         default: next_phase = cur;
      endcase
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable generator: divides the master clock by CLK_DIV and emits a
// one-clk pix_en on the cycle the divider wraps. No derived clocks are created.
module pixel_tick_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic pix_en
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             wrap;

   // Divider advances only while enabled; a held divider keeps the pixel phase.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      div_d = div_q;
      wrap  = en && (div_q == DIV_LAST);
      if (en) begin
         div_d = wrap ? '0 : div_q + DIV_W'(1);
      end
      // Gated by rst so that CLK_DIV=1 still shows pix_en=0 while in reset.
      pix_en = wrap && !rst;
   end

   // Divider state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, regardless of statement order.
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA timing controller: scan counters, phase FSMs and registered decode of
// hsync/vsync/video_on and line/frame markers, all advanced by pix_en on clk.
module vga_sync_ctrl
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pix_en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // The phase FSMs need every phase to be at least one unit wide.
   if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 ||
       H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_sync_ctrl: illegal timing parameters");
   end

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .pix_en (pix_en)
   );

   logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             h_wrap;
   scan_phase_e      h_phase_q, h_phase_d, v_phase_q, v_phase_d;
   logic             hsync_q, hsync_d, vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             line_start_q, line_start_d, frame_start_q, frame_start_d;

   // Next scan position and decode, so outputs register in the same clk as the counts.
   always_comb begin
      h_wrap = (hcount_q == H_LAST);
      h_nxt  = h_wrap ? '0 : hcount_q + CNT_W'(1);
      v_nxt  = vcount_q;
      if (h_wrap) begin
         v_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
      end

      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      h_phase_d     = h_phase_q;
      v_phase_d     = v_phase_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (pix_en) begin
         hcount_d  = h_nxt;
         vcount_d  = v_nxt;
         h_phase_d = next_phase(h_phase_q, 32'(h_nxt), H_ACTIVE, H_FP, H_SYNC);
         if (h_wrap) begin
            v_phase_d = next_phase(v_phase_q, 32'(v_nxt), V_ACTIVE, V_FP, V_SYNC);
         end
         hsync_d       = (h_phase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = (v_phase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
         video_on_d    = (h_phase_d == ACTIVE) && (v_phase_d == ACTIVE);
         line_start_d  = (h_nxt == '0);
         frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      end
   end

   // Scan state: reset parks on the last pixel so the first tick lands on (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q      <= H_LAST;
         vcount_q      <= V_LAST;
         h_phase_q     <= BACK;
         v_phase_q     <= BACK;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         h_phase_q     <= h_phase_d;
         v_phase_q     <= v_phase_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Self-checking bench for vga_sync_ctrl: default horizontal timing with a short
// vertical frame so whole frames fit in a short run. A linear pixel-index model
// predicts every clk; expectations go through a queue and are compared on the
// falling edge. Targeted measurements cover sync widths, frame period, pause
// and mid-frame reset.
module tb_vga_sync_ctrl;
   import vga_timing_pkg::*;

   localparam int unsigned CLK_DIV    = 2;
   localparam int unsigned H_ACTIVE   = DEF_H_ACTIVE;
   localparam int unsigned H_FP       = DEF_H_FP;
   localparam int unsigned H_SYNC     = DEF_H_SYNC;
   localparam int unsigned H_TOTAL    = DEF_H_TOTAL;
   localparam int unsigned V_ACTIVE   = 6;
   localparam int unsigned V_FP       = 2;
   localparam int unsigned V_SYNC     = 2;
   localparam int unsigned V_BP       = 2;
   localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned PIXELS     = H_TOTAL * V_TOTAL;
   localparam int unsigned FRAME_CLKS = PIXELS * CLK_DIV;
   localparam bit          SYNC_POL   = 1'b0;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       ls;
      logic       fs;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       pix_en;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       line_start;
   logic       frame_start;

   vga_sync_ctrl #(
      .CLK_DIV  (CLK_DIV),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .pix_en      (pix_en),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned m_div;
   int unsigned m_pix;
   obs_t        m_out;
   obs_t        q_exp[$];

   function automatic obs_t reset_obs();
      obs_t o;
      o.h  = 10'(H_TOTAL - 1);
      o.v  = 10'(V_TOTAL - 1);
      o.hs = !SYNC_POL;
      o.vs = !SYNC_POL;
      o.vo = 1'b0;
      o.ls = 1'b0;
      o.fs = 1'b0;
      return o;
   endfunction

   function automatic obs_t decode(input int unsigned pix);
      obs_t        o;
      int unsigned h;
      int unsigned v;
      h    = pix % H_TOTAL;
      v    = pix / H_TOTAL;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
      o.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
      o.vo = (h < H_ACTIVE) && (v < V_ACTIVE);
      o.ls = (h == 0);
      o.fs = (pix == 0);
      return o;
   endfunction

   function automatic obs_t dut_obs();
      return {hcount, vcount, hsync, vsync, video_on, line_start, frame_start};
   endfunction

   // One clk: drive inputs after the falling edge, predict, compare at the next falling edge.
   task automatic cycle(input logic en_v, input logic rst_v);
      obs_t exp_o;
      logic exp_pe;
      en  = en_v;
      rst = rst_v;
      #1;
      if (rst_v) begin
         m_div = 0;
         m_pix = PIXELS - 1;
         m_out = reset_obs();
         check("rst_async", 32'(dut_obs()), 32'(m_out));
      end
      exp_pe = !rst_v && en_v && (m_div == CLK_DIV - 1);
      check("pix_en", 32'(pix_en), 32'(exp_pe));
      if (!rst_v && en_v && exp_pe) begin
         m_div = 0;
         m_pix = (m_pix + 1) % PIXELS;
         m_out = decode(m_pix);
      end else begin
         if (!rst_v && en_v) m_div++;
         m_out.ls = 1'b0;
         m_out.fs = 1'b0;
      end
      q_exp.push_back(m_out);
      @(negedge clk);
      exp_o = q_exp.pop_front();
      check("scan", 32'(dut_obs()), 32'(exp_o));
   endtask

   // ---------------- measurement monitor ----------------
   int         cyc         = 0;
   int         last_fs_cyc = -1;
   int         fs_period   = -1;
   int         hs_cnt      = 0;
   int         hs_min      = 1023;
   int         hs_max      = -1;
   int         vs_cnt      = 0;
   int         vs_min      = 1023;
   int         vs_max      = -1;
   int         vo_fall_h   = -1;
   logic       prev_vo     = 1'b0;
   logic [9:0] prev_h      = '0;

   always @(negedge clk) begin
      cyc++;
      if (frame_start) begin
         if (last_fs_cyc >= 0 && fs_period < 0) fs_period = cyc - last_fs_cyc;
         last_fs_cyc = cyc;
      end
      if (vcount == 0 && hcount != prev_h && hsync == SYNC_POL) begin
         hs_cnt++;
         if (int'(hcount) < hs_min) hs_min = int'(hcount);
         if (int'(hcount) > hs_max) hs_max = int'(hcount);
      end
      if (line_start && vsync == SYNC_POL) begin
         vs_cnt++;
         if (int'(vcount) < vs_min) vs_min = int'(vcount);
         if (int'(vcount) > vs_max) vs_max = int'(vcount);
      end
      if (prev_vo && !video_on && vo_fall_h < 0) vo_fall_h = int'(hcount);
      prev_vo = video_on;
      prev_h  = hcount;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] v_saved;
      int         n_res;
      rst = 1'b0;
      en  = 1'b0;
      #2;

      // Reset state.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      check("rst_hcount", 32'(hcount), H_TOTAL - 1);
      check("rst_vcount", 32'(vcount), V_TOTAL - 1);
      check("rst_sync", 32'({hsync, vsync}), 32'({!SYNC_POL, !SYNC_POL}));

      // First tick after release lands on (0,0) with both markers.
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      check("first_pos", 32'({vcount, hcount}), 32'd0);
      check("first_marks", 32'({frame_start, line_start, video_on}), 32'b111);

      // Complete one full frame plus the wrap into the next.
      for (int i = 0; i < int'(FRAME_CLKS) + 2; i++) cycle(1'b1, 1'b0);
      #1;
      check("hs_ticks", 32'(hs_cnt), H_SYNC);
      check("hs_first", 32'(hs_min), H_ACTIVE + H_FP);
      check("hs_last", 32'(hs_max), H_ACTIVE + H_FP + H_SYNC - 1);
      check("vo_fall_h", 32'(vo_fall_h), H_ACTIVE);
      check("vs_lines", 32'(vs_cnt), V_SYNC);
      check("vs_first", 32'(vs_min), V_ACTIVE + V_FP);
      check("vs_last", 32'(vs_max), V_ACTIVE + V_FP + V_SYNC - 1);
      check("frame_period", 32'(fs_period), FRAME_CLKS);

      // Pause mid-line at hcount=300.
      for (int i = 0; i < int'(4 * H_TOTAL) && hcount != 10'd300; i++) cycle(1'b1, 1'b0);
      check("reach_h300", 32'(hcount), 32'd300);
      v_saved = vcount;
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
      check("pause_h", 32'(hcount), 32'd300);
      check("pause_v", 32'(vcount), 32'(v_saved));
      n_res = 0;
      for (int i = 0; i < 8 && hcount == 10'd300; i++) begin
         cycle(1'b1, 1'b0);
         n_res++;
      end
      check("resume_h", 32'(hcount), 32'd301);
      check("resume_lat", 32'(n_res), CLK_DIV);

      // Reset in the middle of a frame.
      for (int i = 0; i < int'(FRAME_CLKS) && !(hcount == 10'd400 && vcount == 10'd5); i++)
         cycle(1'b1, 1'b0);
      check("reach_400_5", 32'({vcount, hcount}), 32'({10'd5, 10'd400}));
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      check("restart_pos", 32'({vcount, hcount}), 32'd0);
      check("restart_fs", 32'({frame_start, line_start}), 32'b11);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
